pwm_dir_driver: RTL and testbench

Downstream actuator stage for the PID controller. Takes the controller's 16-bit offset-binary command word and its one-cycle valid strobe, and converts it to sign/magnitude. The magnitude drives a fixed-frequency PWM output and the sign drives a direction output, so the block feeds the motor H-bridge directly. New commands take effect only at PWM period boundaries. A direction reversal inserts a dead-time gap.

---
 rtl/pwm_dir_driver.sv | 173 +++++++++++++++++
 tb/tb_pwm_dir_driver.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_dir_driver.sv
// Sign/magnitude PWM actuator stage for the PID controller: offset-binary command in,
// PWM + direction out. Optional reversal dead time is enabled by defining PWM_DEADTIME_EN.
module pwm_dir_driver #(
  parameter int unsigned OFFSET    = 32000,
  parameter int unsigned FULLSCALE = 32000,
  parameter int unsigned SHIFT     = 5,
  parameter int unsigned DEADTIME  = 50
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic [15:0] i_un,
  input  logic        i_valid,
  output logic        o_pwm,
  output logic        o_dir,
  output logic [15:0] o_duty,
  output logic        o_sat,
  output logic        o_dead
);

  localparam int unsigned PERIOD      = FULLSCALE >> SHIFT;
  localparam logic [15:0] PERIOD_M1   = 16'(PERIOD - 1);
  localparam logic [16:0] OFFSET_W    = 17'(OFFSET);
  localparam logic [16:0] FULLSCALE_W = 17'(FULLSCALE);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DEAD
  } state_t;

  state_t      state;
  logic [15:0] cnt;
  logic        pend;
  logic        dir_p;
  logic [15:0] duty_p;

  // Capture path: offset-binary to sign/magnitude, clamp, scale to duty counts.
  logic [16:0] un_w;
  logic [16:0] mag;
  logic [16:0] mag_clamped;
  logic        cap_dir;
  logic        cap_sat;
  logic [15:0] cap_duty;

  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    un_w        = {1'b0, i_un};
    cap_dir     = (un_w >= OFFSET_W);
    mag         = cap_dir ? (un_w - OFFSET_W) : (OFFSET_W - un_w);
    cap_sat     = (mag > FULLSCALE_W);
    mag_clamped = cap_sat ? FULLSCALE_W : mag;
    cap_duty    = 16'(mag_clamped >> SHIFT);
  end

  logic boundary;
  logic same_dir;
  logic dead_done;
  logic load_now;
  logic go_dead;

`ifdef PWM_DEADTIME_EN
  localparam int unsigned DW = $clog2(DEADTIME + 1);
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEADTIME - 1);

  logic [DW-1:0] dead_cnt;
  logic          dead_q;

  assign same_dir  = (dir_p == o_dir);
  assign dead_done = (dead_cnt == DEAD_LAST);
  assign o_dead    = dead_q;
`else
  logic unused_deadtime;

  // A reversal is just another boundary load when dead time is compiled out.
  assign same_dir        = 1'b1;
  assign dead_done       = 1'b0;
  assign o_dead          = 1'b0;
  assign unused_deadtime = ^DEADTIME;
`endif

  assign boundary = (cnt == PERIOD_M1);
  assign load_now = i_en && pend &&
                    ((state == ST_IDLE) ||
                     (state == ST_RUN && boundary && same_dir) ||
                     (state == ST_DEAD && dead_done));
  assign go_dead  = i_en && pend && (state == ST_RUN) && boundary && !same_dir;

  // NOTE: state registers use non-blocking assignments so every update samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      pend   <= 1'b0;
      dir_p  <= 1'b0;
      duty_p <= '0;
      o_pwm  <= 1'b0;
      o_dir  <= 1'b0;
      o_duty <= '0;
      o_sat  <= 1'b0;
`ifdef PWM_DEADTIME_EN
      dead_cnt <= '0;
      dead_q   <= 1'b0;
`endif
    end else begin
      if (!i_en) begin
        state <= ST_IDLE;
        cnt   <= '0;
        o_pwm <= 1'b0;
`ifdef PWM_DEADTIME_EN
        dead_q <= 1'b0;
`endif
      end else if (load_now) begin
        // o_pwm is computed for cnt = 0 of the new period so it starts on the same cycle.
        state  <= ST_RUN;
        cnt    <= '0;
        o_duty <= duty_p;
        o_dir  <= dir_p;
        pend   <= 1'b0;
        o_pwm  <= (duty_p != 16'd0);
`ifdef PWM_DEADTIME_EN
        dead_q <= 1'b0;
`endif
      end else if (go_dead) begin
        state <= ST_DEAD;
        o_pwm <= 1'b0;
`ifdef PWM_DEADTIME_EN
        dead_cnt <= '0;
        dead_q   <= 1'b1;
`endif
      end else begin
        unique case (state)
          ST_IDLE: begin
            cnt   <= '0;
            o_pwm <= 1'b0;
          end
          ST_RUN: begin
            if (boundary) begin
              cnt   <= '0;
              o_pwm <= (o_duty != 16'd0);
            end else begin
              cnt   <= cnt + 16'd1;
              o_pwm <= ((cnt + 16'd1) < o_duty);
            end
          end
          ST_DEAD: begin
            o_pwm <= 1'b0;
`ifdef PWM_DEADTIME_EN
            if (dead_done) begin
              state  <= ST_IDLE;
              dead_q <= 1'b0;
            end else begin
              dead_cnt <= dead_cnt + 1'b1;
            end
`else
            state <= ST_IDLE;
`endif
          end
          default: state <= ST_IDLE;
        endcase
      end

      // Capture comes last so a strobe on a load cycle re-arms pending with the new command.
      if (i_valid) begin
        dir_p  <= cap_dir;
        duty_p <= cap_duty;
        pend   <= 1'b1;
        o_sat  <= cap_sat;
      end
    end
  end

endmodule

// File: tb/tb_pwm_dir_driver.sv
// Directed self-checking bench for pwm_dir_driver; expectations follow PWM_DEADTIME_EN.
module tb_pwm_dir_driver;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_en;
  logic [15:0] i_un;
  logic        i_valid;
  logic        o_pwm;
  logic        o_dir;
  logic [15:0] o_duty;
  logic        o_sat;
  logic        o_dead;

  int checks = 0;
  int errors = 0;
  int high_cnt;
  int dead_cnt;

  pwm_dir_driver dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_en),
    .i_un    (i_un),
    .i_valid (i_valid),
    .o_pwm   (o_pwm),
    .o_dir   (o_dir),
    .o_duty  (o_duty),
    .o_sat   (o_sat),
    .o_dead  (o_dead)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic skip(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [15:0] v);
    i_valid = 1'b1;
    i_un    = v;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  // Samples the current cycle and the following n-1, leaving time one cycle past the last sample.
  task automatic measure(input int n, output int high, output int dead);
    high = 0;
    dead = 0;
    for (int i = 0; i < n; i++) begin
      high += int'(o_pwm);
      dead += int'(o_dead);
      @(posedge i_clk);
      #1;
    end
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_en    = 1'b0;
    i_un    = 16'd0;
    i_valid = 1'b0;
    #3;
    check("rst_pwm",  32'(o_pwm),  32'd0);
    check("rst_duty", 32'(o_duty), 32'd0);
    check("rst_dir",  32'(o_dir),  32'd0);
    check("rst_sat",  32'(o_sat),  32'd0);
    check("rst_dead", 32'(o_dead), 32'd0);
    skip(2);
    i_rst_n = 1'b1;
    i_en    = 1'b1;
    skip(5);
    check("idle_pwm",  32'(o_pwm),  32'd0);
    check("idle_duty", 32'(o_duty), 32'd0);

    // 48000 -> m 16000 -> duty 500, forward; high on the second edge after the strobe.
    strobe(16'd48000);
    check("cap_sat0",     32'(o_sat),  32'd0);
    check("cap_pwm_low",  32'(o_pwm),  32'd0);
    check("cap_duty_old", 32'(o_duty), 32'd0);
    skip(1);
    check("load_duty500", 32'(o_duty), 32'd500);
    check("load_dir1",    32'(o_dir),  32'd1);
    check("load_pwm_hi",  32'(o_pwm),  32'd1);
    measure(1000, high_cnt, dead_cnt);
    check("high_500", 32'(high_cnt), 32'd500);

    // 32000 -> duty 0, output constantly low.
    strobe(16'd32000);
    skip(999);
    check("duty0",     32'(o_duty), 32'd0);
    check("duty0_dir", 32'(o_dir),  32'd1);
    measure(1000, high_cnt, dead_cnt);
    check("high_0", 32'(high_cnt), 32'd0);

    // 65535 -> clamp to full scale, duty 1000, sticky sat; no gap across two wraps.
    strobe(16'd65535);
    check("sat_on_capture", 32'(o_sat), 32'd1);
    skip(999);
    check("duty_clamp", 32'(o_duty), 32'd1000);
    measure(2000, high_cnt, dead_cnt);
    check("high_full_fwd", 32'(high_cnt), 32'd2000);

    // 40000 -> m 8000 -> duty 250, sat cleared on capture.
    strobe(16'd40000);
    check("sat_clear",     32'(o_sat),  32'd0);
    check("duty_pre_bnd",  32'(o_duty), 32'd1000);
    skip(999);
    check("duty250", 32'(o_duty), 32'd250);
    measure(1000, high_cnt, dead_cnt);
    check("high_250", 32'(high_cnt), 32'd250);

    // Two strobes in one period: last one (56000 -> 750) wins.
    strobe(16'd40000);
    skip(10);
    strobe(16'd56000);
    skip(988);
    check("last_wins_750", 32'(o_duty), 32'd750);
    measure(1000, high_cnt, dead_cnt);
    check("high_750", 32'(high_cnt), 32'd750);

    // Strobe on the boundary cycle is held until the following boundary.
    skip(999);
    strobe(16'd48000);
    check("coincident_held", 32'(o_duty), 32'd750);
    skip(1000);
    check("coincident_applied", 32'(o_duty), 32'd500);
    check("coincident_dir",     32'(o_dir),  32'd1);

    // Reversal: 16000 -> reverse, m 16000, duty 500.
    strobe(16'd16000);
    skip(998);
    check("rev_bnd_dir",  32'(o_dir),  32'd1);
    check("rev_bnd_dead", 32'(o_dead), 32'd0);
    skip(1);
`ifdef PWM_DEADTIME_EN
    check("dead_dir_held", 32'(o_dir), 32'd1);
    measure(50, high_cnt, dead_cnt);
    check("dead_len",      32'(dead_cnt), 32'd50);
    check("dead_pwm_low",  32'(high_cnt), 32'd0);
`endif
    check("rev_dir0",   32'(o_dir),  32'd0);
    check("rev_duty",   32'(o_duty), 32'd500);
    check("rev_pwm_hi", 32'(o_pwm),  32'd1);
    check("rev_dead0",  32'(o_dead), 32'd0);
    measure(1000, high_cnt, dead_cnt);
    check("rev_high_500", 32'(high_cnt), 32'd500);

    // 0 -> reverse full scale, duty 1000, high across the wrap.
    strobe(16'd0);
    skip(999);
    check("rev_full_duty", 32'(o_duty), 32'd1000);
    check("rev_full_dir",  32'(o_dir),  32'd0);
    check("rev_full_sat",  32'(o_sat),  32'd0);
    measure(2000, high_cnt, dead_cnt);
    check("high_full_rev", 32'(high_cnt), 32'd2000);

    // Mid-period asynchronous reset while the output is high.
    skip(300);
    check("pre_rst_pwm", 32'(o_pwm), 32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("async_rst_pwm",  32'(o_pwm),  32'd0);
    check("async_rst_duty", 32'(o_duty), 32'd0);
    check("async_rst_dead", 32'(o_dead), 32'd0);
    skip(2);
    i_rst_n = 1'b1;
    skip(20);
    check("post_rst_idle_pwm",  32'(o_pwm),  32'd0);
    check("post_rst_idle_duty", 32'(o_duty), 32'd0);
    strobe(16'd48000);
    skip(1);
    check("post_rst_run_duty", 32'(o_duty), 32'd500);
    check("post_rst_run_pwm",  32'(o_pwm),  32'd1);

    // Disable forces the output off on the next edge.
    i_en = 1'b0;
    skip(1);
    check("disable_pwm", 32'(o_pwm), 32'd0);
    skip(5);
    check("disable_hold_pwm", 32'(o_pwm), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
